// File: rtl/onewire_pkg.sv
// Shared definitions for the byte-level 1-Wire controller: command encodings,
// controller states and default slot timing (all in clk cycles).
package onewire_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_NOP   = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_HIGH,
        ST_SLOT,
        ST_DONE
    } state_e;

    localparam int DEF_T_RST_LOW  = 480;
    localparam int DEF_T_RST_HIGH = 480;
    localparam int DEF_T_PRES     = 70;
    localparam int DEF_T_SLOT     = 60;
    localparam int DEF_T_REC      = 2;
    localparam int DEF_T_LOW_W1   = 6;
    localparam int DEF_T_LOW_W0   = 56;
    localparam int DEF_T_LOW_R    = 2;
    localparam int DEF_T_SAMPLE   = 12;
    localparam int DEF_CNT_W      = 10;

endpackage

// File: rtl/onewire_if.sv
// Host-side command/response bundle of the 1-Wire controller.
interface onewire_if;
    import onewire_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    cmd_op_e    cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_presence;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence, busy
    );

endinterface

// File: rtl/onewire_slot.sv
// Single 1-Wire bit-slot generator: drives the low phase, samples a read bit
// and flags the last cycle of the slot (including recovery).
module onewire_slot #(
    parameter int T_SLOT   = 60,
    parameter int T_REC    = 2,
    parameter int T_LOW_W1 = 6,
    parameter int T_LOW_W0 = 56,
    parameter int T_LOW_R  = 2,
    parameter int T_SAMPLE = 12,
    parameter int CNT_W    = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_read,
    input  logic wbit,
    input  logic dq_in,
    output logic dq_oe,
    output logic done,
    output logic rbit
);

    localparam int SLOT_LEN = T_SLOT + T_REC;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] low_len;
    logic             active_reg;
    logic             is_read_reg;
    logic             wbit_reg;
    logic             rbit_reg;

    always_comb begin
        low_len = CNT_W'(T_LOW_W0);
        if (is_read_reg) begin
            low_len = CNT_W'(T_LOW_R);
        end else if (wbit_reg) begin
            low_len = CNT_W'(T_LOW_W1);
        end
    end

    assign dq_oe = active_reg && (cnt_reg < low_len);
    assign done  = active_reg && (cnt_reg == CNT_W'(SLOT_LEN - 1));
    assign rbit  = rbit_reg;

    // A start coinciding with done chains the next slot with no idle cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg     <= '0;
            active_reg  <= 1'b0;
            is_read_reg <= 1'b0;
            wbit_reg    <= 1'b0;
            rbit_reg    <= 1'b0;
        end else begin
            if (start) begin
                cnt_reg     <= '0;
                active_reg  <= 1'b1;
                is_read_reg <= is_read;
                wbit_reg    <= wbit;
            end else if (done) begin
                cnt_reg    <= '0;
                active_reg <= 1'b0;
            end else if (active_reg) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (active_reg && is_read_reg && (cnt_reg == CNT_W'(T_SAMPLE))) begin
                rbit_reg <= dq_in;
            end
        end
    end

endmodule

// File: rtl/onewire_ctrl.sv
// Byte-level 1-Wire controller: sequences reset/presence, write-byte and
// read-byte transactions on an open-drain DQ line.
module onewire_ctrl
    import onewire_pkg::*;
#(
    parameter int T_RST_LOW  = DEF_T_RST_LOW,
    parameter int T_RST_HIGH = DEF_T_RST_HIGH,
    parameter int T_PRES     = DEF_T_PRES,
    parameter int T_SLOT     = DEF_T_SLOT,
    parameter int T_REC      = DEF_T_REC,
    parameter int T_LOW_W1   = DEF_T_LOW_W1,
    parameter int T_LOW_W0   = DEF_T_LOW_W0,
    parameter int T_LOW_R    = DEF_T_LOW_R,
    parameter int T_SAMPLE   = DEF_T_SAMPLE,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic      clk,
    input  logic      reset,
    onewire_if.slave  bus,
    output logic      dq_oe,
    input  logic      dq_in
);

    if (!(T_LOW_R < T_SAMPLE && T_SAMPLE < T_SLOT && T_LOW_W1 < T_LOW_W0 &&
          T_LOW_W0 <= T_SLOT && T_PRES < T_RST_HIGH)) begin : g_bad_timing
        $error("onewire_ctrl: illegal timing parameter combination");
    end
    if (T_RST_LOW >= 2**CNT_W || T_RST_HIGH >= 2**CNT_W ||
        T_SLOT + T_REC >= 2**CNT_W) begin : g_bad_cnt_w
        $error("onewire_ctrl: CNT_W too narrow for timing parameters");
    end

    state_e           state_reg, state_next;
    cmd_op_e          op_reg;
    logic [7:0]       wdata_reg;
    logic [7:0]       shadow_reg;
    logic [7:0]       shadow_merged;
    logic [7:0]       rsp_data_reg;
    logic             rsp_presence_reg;
    logic [CNT_W-1:0] rst_cnt_reg;
    logic [2:0]       bit_idx_reg;

    logic accept;
    logic slot_start, slot_is_read, slot_wbit;
    logic slot_dq_oe, slot_done, slot_rbit;

    assign accept = bus.cmd_valid && (state_reg == ST_IDLE);

    // On acceptance the first slot must start in the same edge, so its
    // parameters come straight from the bus instead of the latched copy.
    always_comb begin
        state_next   = state_reg;
        slot_start   = 1'b0;
        slot_is_read = (op_reg == OP_READ);
        slot_wbit    = wdata_reg[bit_idx_reg + 3'd1];
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    slot_is_read = (bus.cmd_op == OP_READ);
                    slot_wbit    = bus.cmd_data[0];
                    unique case (bus.cmd_op)
                        OP_RESET: state_next = ST_RST_LOW;
                        OP_WRITE, OP_READ: begin
                            state_next = ST_SLOT;
                            slot_start = 1'b1;
                        end
                        default: state_next = ST_DONE;
                    endcase
                end
            end
            ST_RST_LOW: begin
                if (rst_cnt_reg == CNT_W'(T_RST_LOW - 1)) state_next = ST_RST_HIGH;
            end
            ST_RST_HIGH: begin
                if (rst_cnt_reg == CNT_W'(T_RST_HIGH - 1)) state_next = ST_DONE;
            end
            ST_SLOT: begin
                if (slot_done) begin
                    if (bit_idx_reg == 3'd7) state_next = ST_DONE;
                    else                     slot_start = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_shadow
        assign shadow_merged[gi] = (bit_idx_reg == 3'(gi)) ? slot_rbit : shadow_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            op_reg           <= OP_NOP;
            wdata_reg        <= '0;
            shadow_reg       <= '0;
            rsp_data_reg     <= '0;
            rsp_presence_reg <= 1'b0;
            rst_cnt_reg      <= '0;
            bit_idx_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg     <= bus.cmd_op;
                wdata_reg  <= bus.cmd_data;
                shadow_reg <= '0;
            end
            if (state_next != state_reg) begin
                rst_cnt_reg <= '0;
                bit_idx_reg <= '0;
            end else begin
                rst_cnt_reg <= rst_cnt_reg + CNT_W'(1);
                if (slot_done) bit_idx_reg <= bit_idx_reg + 3'd1;
            end
            if ((state_reg == ST_SLOT) && slot_done && (op_reg == OP_READ)) begin
                shadow_reg <= shadow_merged;
                if (bit_idx_reg == 3'd7) rsp_data_reg <= shadow_merged;
            end
            if ((state_reg == ST_RST_HIGH) && (rst_cnt_reg == CNT_W'(T_PRES))) begin
                rsp_presence_reg <= ~dq_in;
            end
        end
    end

    onewire_slot #(
        .T_SLOT   (T_SLOT),
        .T_REC    (T_REC),
        .T_LOW_W1 (T_LOW_W1),
        .T_LOW_W0 (T_LOW_W0),
        .T_LOW_R  (T_LOW_R),
        .T_SAMPLE (T_SAMPLE),
        .CNT_W    (CNT_W)
    ) u_slot (
        .clk     (clk),
        .reset   (reset),
        .start   (slot_start),
        .is_read (slot_is_read),
        .wbit    (slot_wbit),
        .dq_in   (dq_in),
        .dq_oe   (slot_dq_oe),
        .done    (slot_done),
        .rbit    (slot_rbit)
    );

    assign bus.cmd_ready    = (state_reg == ST_IDLE);
    assign bus.busy         = (state_reg != ST_IDLE);
    assign bus.rsp_valid    = (state_reg == ST_DONE);
    assign bus.rsp_data     = rsp_data_reg;
    assign bus.rsp_presence = rsp_presence_reg;
    assign dq_oe            = (state_reg == ST_RST_LOW) || slot_dq_oe;

endmodule

// File: tb/tb_onewire_ctrl.sv
// Self-checking bench for onewire_ctrl with a reactive 1-Wire slave model.
module tb_onewire_ctrl;
    import onewire_pkg::*;

    localparam int SLOT_P = DEF_T_SLOT + DEF_T_REC;
    localparam int MAXJ   = 1100;

    logic clk = 1'b0;
    logic reset;
    logic dq_oe;
    logic dq_in;

    onewire_if bus();

    onewire_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .dq_oe (dq_oe),
        .dq_in (dq_in)
    );

    always #5 clk = ~clk;

    // Slave model: reacts to the line itself, not to controller internals.
    bit         pres_en = 1'b0;
    bit         rd_en   = 1'b0;
    logic [7:0] rd_byte = 8'h00;
    int         rd_base = 0;
    logic       oe_d = 1'b0;
    int         hi_run = 0;
    int         rise_total = 0;
    int         rise_cnt = 100000;
    int         rel_cnt = 100000;
    int         rd_idx;
    logic       slave_low;

    always @(negedge clk) begin
        oe_d   <= dq_oe;
        hi_run <= dq_oe ? hi_run + 1 : 0;
        if (dq_oe && !oe_d) begin
            rise_total <= rise_total + 1;
            rise_cnt   <= 0;
        end else if (rise_cnt < 100000) begin
            rise_cnt <= rise_cnt + 1;
        end
        if (!dq_oe && oe_d && hi_run >= 400) rel_cnt <= 0;
        else if (rel_cnt < 100000)          rel_cnt <= rel_cnt + 1;
    end

    assign rd_idx    = rise_total - rd_base - 1;
    assign slave_low = (pres_en && rel_cnt >= 15 && rel_cnt < 135) ||
                       (rd_en && rd_idx >= 0 && rd_idx < 8 && !rd_byte[rd_idx[2:0]] && rise_cnt < 30);
    assign dq_in     = ~(dq_oe | slave_low);

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model_d = 8'h00;
    bit         model_p = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input cmd_op_e op);
        case (op)
            OP_RESET: return 1 + DEF_T_RST_LOW + DEF_T_RST_HIGH;
            OP_NOP:   return 1;
            default:  return 1 + 8 * SLOT_P;
        endcase
    endfunction

    function automatic int npulse_of(input cmd_op_e op);
        case (op)
            OP_RESET: return 1;
            OP_NOP:   return 0;
            default:  return 8;
        endcase
    endfunction

    function automatic int plen_of(input cmd_op_e op, input logic [7:0] d, input int k);
        case (op)
            OP_RESET: return DEF_T_RST_LOW;
            OP_READ:  return DEF_T_LOW_R;
            default:  return d[k] ? DEF_T_LOW_W1 : DEF_T_LOW_W0;
        endcase
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!bus.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("wait_idle timeout", 0, 1);
    endtask

    task automatic run_cmd(input string name, input cmd_op_e op, input logic [7:0] data,
                           input bit pres, input logic [7:0] rbyte, input int exp_lat,
                           input logic [7:0] exp_d, input bit exp_p);
        bit tr[0:MAXJ];
        int lat = -1;
        int last = MAXJ;
        int d_at = 0, p_at = 0, rdy_at = 1, busy_at = 0;
        int n_p = 0;
        int p_start[16];
        int p_len[16];
        wait_idle();
        pres_en = pres;
        rd_en   = (op == OP_READ);
        rd_byte = rbyte;
        rd_base = rise_total;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        @(posedge clk);
        tr[0] = 1'b0;
        for (int j = 1; j <= MAXJ; j++) begin
            @(negedge clk);
            if (j == 1) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_op    = cmd_op_e'($urandom_range(0, 3));
                bus.cmd_data  = 8'($urandom);
            end
            tr[j] = dq_oe;
            if (bus.rsp_valid) begin
                lat = j; d_at = bus.rsp_data; p_at = bus.rsp_presence;
                rdy_at = bus.cmd_ready; busy_at = bus.busy; last = j;
                break;
            end
        end
        for (int j = 1; j <= last; j++) begin
            if (tr[j] && !tr[j-1] && n_p < 16) p_start[n_p] = j;
            if (!tr[j] && tr[j-1] && n_p < 16) begin
                p_len[n_p] = j - p_start[n_p];
                n_p++;
            end
        end
        $display("cmd %s op=%0d data=0x%02h lat=%0d rsp_data=0x%02h pres=%0d pulses=%0d",
                 name, op, data, lat, d_at, p_at, n_p);
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " rsp_data"}, d_at, exp_d);
        chk({name, " rsp_presence"}, p_at, exp_p);
        chk({name, " cmd_ready in DONE"}, rdy_at, 0);
        chk({name, " busy in DONE"}, busy_at, 1);
        chk({name, " pulse count"}, n_p, npulse_of(op));
        for (int k = 0; k < n_p && k < npulse_of(op); k++) begin
            chk($sformatf("%s pulse%0d start", name, k), p_start[k], 1 + k * SLOT_P);
            chk($sformatf("%s pulse%0d len", name, k), p_len[k], plen_of(op, data, k));
        end
    endtask

    typedef struct {
        cmd_op_e    op;
        logic [7:0] data;
        bit         pres;
        logic [7:0] rbyte;
        int         lat;
        logic [7:0] exp_d;
        bit         exp_p;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int first, second, d1, d2, rdy1, nv, noe;
        cmd_op_e    rop;
        logic [7:0] rdat, rbyte;
        bit         rpres;

        vecs[0] = '{OP_RESET, 8'h00, 1'b1, 8'h00, 961, 8'h00, 1'b1};
        vecs[1] = '{OP_RESET, 8'h00, 1'b0, 8'h00, 961, 8'h00, 1'b0};
        vecs[2] = '{OP_WRITE, 8'hA5, 1'b0, 8'h00, 497, 8'h00, 1'b0};
        vecs[3] = '{OP_READ,  8'h00, 1'b0, 8'h3C, 497, 8'h3C, 1'b0};
        vecs[4] = '{OP_NOP,   8'h5A, 1'b0, 8'h00, 1,   8'h3C, 1'b0};
        vecs[5] = '{OP_RESET, 8'hFF, 1'b1, 8'h00, 961, 8'h3C, 1'b1};
        vecs[6] = '{OP_READ,  8'h00, 1'b1, 8'h81, 497, 8'h81, 1'b1};

        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset dq_oe", dq_oe, 0);
        chk("reset cmd_ready", bus.cmd_ready, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset rsp_data", bus.rsp_data, 0);
        chk("reset rsp_presence", bus.rsp_presence, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].pres,
                    vecs[i].rbyte, vecs[i].lat, vecs[i].exp_d, vecs[i].exp_p);
            model_d = vecs[i].exp_d;
            model_p = vecs[i].exp_p;
        end

        // Reset in the middle of write slot 3 (bit 3 of 0xA5 is 0: long low).
        wait_idle();
        rd_en = 1'b0; pres_en = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_data = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (SLOT_P * 3 + 3) @(negedge clk);
        chk("midrst dq_oe before", dq_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst dq_oe", dq_oe, 0);
        chk("midrst cmd_ready", bus.cmd_ready, 1);
        chk("midrst rsp_data", bus.rsp_data, 0);
        chk("midrst rsp_presence", bus.rsp_presence, 0);
        reset = 1'b0;
        nv = 0; noe = 0;
        repeat (600) begin
            @(negedge clk);
            if (bus.rsp_valid) nv++;
            if (dq_oe) noe++;
        end
        $display("midrst: rsp_valid count=%0d dq_oe cycles=%0d", nv, noe);
        chk("midrst no rsp_valid", nv, 0);
        chk("midrst bus quiet", noe, 0);
        chk("midrst cmd_ready after", bus.cmd_ready, 1);
        model_d = 8'h00; model_p = 1'b0;
        run_cmd("read_after_rst", OP_READ, 8'h00, 1'b0, 8'h96, 497, 8'h96, 1'b0);
        model_d = 8'h96;

        // Back-to-back: READ then NOP with cmd_valid held high.
        wait_idle();
        pres_en = 1'b0; rd_en = 1'b1; rd_byte = 8'h3C; rd_base = rise_total;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_READ; bus.cmd_data = 8'h00;
        @(posedge clk);
        first = -1; second = -1; d1 = 0; d2 = 0; rdy1 = 1;
        for (int j = 1; j <= MAXJ; j++) begin
            @(negedge clk);
            if (j == 1) begin
                bus.cmd_op   = OP_NOP;
                bus.cmd_data = 8'($urandom);
            end
            if (bus.rsp_valid) begin
                if (first < 0) begin
                    first = j; d1 = bus.rsp_data; rdy1 = bus.cmd_ready;
                end else begin
                    second = j; d2 = bus.rsp_data;
                    break;
                end
            end
        end
        bus.cmd_valid = 1'b0;
        $display("b2b: read rsp at %0d data=0x%02h, nop rsp at %0d data=0x%02h", first, d1, second, d2);
        chk("b2b read latency", first, 497);
        chk("b2b read data", d1, 8'h3C);
        chk("b2b ready in DONE", rdy1, 0);
        chk("b2b nop gap", second - first, 2);
        chk("b2b nop data", d2, 8'h3C);
        model_d = 8'h3C;

        for (int r = 0; r < 6; r++) begin
            rop   = cmd_op_e'($urandom_range(0, 3));
            rdat  = 8'($urandom);
            rbyte = 8'($urandom);
            rpres = 1'($urandom_range(0, 1));
            if (rop == OP_READ)  model_d = rbyte;
            if (rop == OP_RESET) model_p = rpres;
            run_cmd($sformatf("rnd%0d", r), rop, rdat, rpres, rbyte, lat_of(rop), model_d, model_p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
